// File: rtl/photon_sequencer.sv
// photon_sequencer: owns the photon hash core's bus on behalf of NREQ requesters.
// Each granted job loads 8 message words, hashes, polls for ready (with timeout),
// then streams the 8 digest words back to the owner before pulsing done.
module photon_sequencer #(
  parameter int NREQ     = 2,
  parameter int HASH_GAP = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [32*NREQ-1:0]   msg_data_i,
  output logic [2:0]           msg_idx_o,
  output logic [NREQ-1:0]      grant_o,
  output logic                 dig_valid_o,
  output logic [2:0]           dig_idx_o,
  output logic [31:0]          dig_data_o,
  output logic [NREQ-1:0]      done_o,
  output logic [NREQ-1:0]      err_o,
  output logic                 busy_o,
  output logic [2:0]           p_opcode_o,
  output logic [2:0]           p_addr_o,
  output logic [31:0]          p_data_in_o,
  input  logic [31:0]          p_data_out_i
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(HASH_GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_HASH  = 3'd3;
  localparam logic [2:0] OP_CHECK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HASH, S_GAP, S_POLL, S_READ, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [TW-1:0]       to_q, to_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       ptr_q, ptr_d;     // first requester considered next time
  logic [NREQ-1:0]     grant_q, grant_d;
  logic                err_q, err_d;

  logic [NREQ-1:0][31:0] msg_w;
  logic [2*NREQ-1:0]     req_dbl;
  logic [NREQ-1:0]       req_rot;
  logic                  pick_ok;
  logic [OW-1:0]         pick;

  assign msg_w   = msg_data_i;
  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl[ptr_q +: NREQ];

  // Round-robin pick: first asserted request at or after ptr_q
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_ok = 1'b1;
        pick    = OW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Next-state and bus/requester outputs; all outputs decode from the current state
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    to_d        = to_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    err_d       = err_q;
    p_opcode_o  = OP_NONE;
    p_addr_o    = '0;
    p_data_in_o = '0;
    msg_idx_o   = idx_q;
    dig_valid_o = 1'b0;
    dig_idx_o   = '0;
    dig_data_o  = '0;
    done_o      = '0;
    err_o       = '0;
    busy_o      = (state_q != S_IDLE);
    grant_o     = grant_q;

    case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          state_d       = S_LOAD;
          idx_d         = '0;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          err_d         = 1'b0;
        end
      end
      S_LOAD: begin
        p_opcode_o  = OP_WRITE;
        p_addr_o    = idx_q;
        p_data_in_o = msg_w[owner_q];
        idx_d       = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_HASH;
      end
      S_HASH: begin
        p_opcode_o = OP_HASH;
        gap_d      = '0;
        state_d    = S_GAP;
      end
      S_GAP: begin
        // Let the core leave its wait state before ready is sampled
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(HASH_GAP - 1)) begin
          state_d = S_POLL;
          to_d    = '0;
        end
      end
      S_POLL: begin
        p_opcode_o = OP_CHECK;
        if (p_data_out_i[0]) begin
          state_d = S_READ;
          idx_d   = '0;
        end else begin
          to_d = to_q + 1'b1;
          if (to_q == TW'(TIMEOUT - 1)) begin
            state_d = S_FIN;
            err_d   = 1'b1;
          end
        end
      end
      S_READ: begin
        p_opcode_o  = OP_READ;
        p_addr_o    = idx_q;
        dig_valid_o = 1'b1;
        dig_idx_o   = idx_q;
        dig_data_o  = p_data_out_i;
        idx_d       = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_FIN;
      end
      S_FIN: begin
        done_o  = grant_q;
        err_o   = err_q ? grant_q : '0;
        grant_d = '0;
        ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any job without a done pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_photon_sequencer.sv
// Directed bench for photon_sequencer with a small behavioural photon core.
module tb_photon_sequencer;
  localparam int NREQ = 2, HASH_GAP = 2, TIMEOUT = 16;
  localparam logic [2:0] OP_NONE = 3'd0, OP_READ = 3'd1, OP_WRITE = 3'd2,
                         OP_HASH = 3'd3, OP_CHECK = 3'd4;

  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  req = '0;
  logic [63:0] msg_data;
  logic [2:0]  msg_idx, dig_idx, p_opcode, p_addr;
  logic [1:0]  grant, done, err;
  logic        dig_valid, busy;
  logic [31:0] dig_data, p_data_in, p_data_out;

  int pass = 0, tot = 0;

  photon_sequencer #(.NREQ(NREQ), .HASH_GAP(HASH_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .msg_data_i(msg_data), .msg_idx_o(msg_idx),
    .grant_o(grant), .dig_valid_o(dig_valid), .dig_idx_o(dig_idx), .dig_data_o(dig_data),
    .done_o(done), .err_o(err), .busy_o(busy), .p_opcode_o(p_opcode), .p_addr_o(p_addr),
    .p_data_in_o(p_data_in), .p_data_out_i(p_data_out)
  );

  always #5 clk = ~clk;

  // requester message tables, fetched combinationally through msg_idx
  logic [31:0] msg_tab [2][8];
  assign msg_data = {msg_tab[1][msg_idx], msg_tab[0][msg_idx]};

  // photon core stub: ready 5 cycles after HASH unless forced busy
  logic [31:0] core_in [8];
  logic [31:0] core_out [8];
  int          core_cnt;
  logic        force_busy = 1'b0;
  logic        core_ready;
  assign core_ready = (core_cnt == 0) && !force_busy;

  always @(posedge clk) begin
    if (rst) begin
      core_cnt <= 0;
      for (int i = 0; i < 8; i++) begin core_in[i] <= '0; core_out[i] <= '0; end
    end else begin
      case (p_opcode)
        OP_WRITE: core_in[p_addr] <= p_data_in;
        OP_HASH: begin
          core_cnt <= 5;
          for (int i = 0; i < 8; i++)
            core_out[i] <= {core_in[i][30:0], core_in[i][31]} ^ core_in[7-i] ^ 32'h5A5A0000;
        end
        default: if (core_cnt != 0) core_cnt <= core_cnt - 1;
      endcase
    end
  end

  always_comb begin
    p_data_out = '0;
    if (p_opcode == OP_CHECK) p_data_out = {31'b0, core_ready};
    else if (p_opcode == OP_READ) p_data_out = core_out[p_addr];
  end

  function automatic logic [31:0] exp_dig(input int r, input int w);
    return {msg_tab[r][w][30:0], msg_tab[r][w][31]} ^ msg_tab[r][7-w] ^ 32'h5A5A0000;
  endfunction

  // per-cycle trace recorded at negedge
  logic [2:0]  l_op [256], l_addr [256], l_di [256];
  logic [31:0] l_din [256], l_dd [256];
  logic        l_dv [256], l_busy [256];
  logic [1:0]  l_gr [256], l_done [256], l_err [256];
  logic [2:0]  s_op [256], s_addr [256];
  logic [31:0] s_din [256], s_dd [256];
  int          n_log;
  logic        drop_at_poll = 1'b0;

  task automatic capture(input int ndone, input int bound, output bit ok);
    int nd;
    nd = 0; n_log = 0;
    while (n_log < bound && nd < ndone) begin
      @(negedge clk);
      l_op[n_log] = p_opcode; l_addr[n_log] = p_addr; l_din[n_log] = p_data_in;
      l_dv[n_log] = dig_valid; l_di[n_log] = dig_idx; l_dd[n_log] = dig_data;
      l_gr[n_log] = grant; l_done[n_log] = done; l_err[n_log] = err; l_busy[n_log] = busy;
      if (drop_at_poll && p_opcode == OP_CHECK) req = '0;
      if (done != '0) nd++;
      n_log++;
    end
    ok = (nd >= ndone);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; force_busy = 1'b0; drop_at_poll = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11;
    repeat (2) @(negedge clk);
    tot++; if (p_opcode !== OP_NONE) $display("FAIL reset_op got %0d want 0", p_opcode); else pass++;
    tot++; if (grant !== 2'b00) $display("FAIL reset_grant got %b want 00", grant); else pass++;
    tot++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass++;
    tot++; if (done !== 2'b00 || err !== 2'b00) $display("FAIL reset_done_err got %b/%b want 00/00", done, err); else pass++;
    tot++; if (dig_valid !== 1'b0) $display("FAIL reset_dig_valid got %b want 0", dig_valid); else pass++;
    req = '0; rst = 1'b0;
    @(negedge clk);
    tot++; if (busy !== 1'b0 || grant !== 2'b00) $display("FAIL idle_after_reset busy=%b grant=%b want 0/00", busy, grant); else pass++;
  endtask

  task automatic test_single();
    bit ok; int nd;
    do_reset();
    req = 2'b01;
    capture(1, 100, ok);
    tot++; if (!ok) $display("FAIL single_done_seen got none want done within 100 cycles"); else pass++;
    tot++; if (n_log + 1 !== 25) $display("FAIL single_latency got %0d want 25", n_log + 1); else pass++;
    for (int i = 0; i < 8; i++) begin
      tot++; if (l_op[i] !== OP_WRITE || l_addr[i] !== 3'(i) || l_din[i] !== msg_tab[0][i])
        $display("FAIL single_write[%0d] got op%0d a%0d d%h want op2 a%0d d%h", i, l_op[i], l_addr[i], l_din[i], i, msg_tab[0][i]);
      else pass++;
      tot++; if (l_gr[i] !== 2'b01) $display("FAIL single_grant[%0d] got %b want 01", i, l_gr[i]); else pass++;
    end
    tot++; if (l_op[8] !== OP_HASH) $display("FAIL single_hash got %0d want 3", l_op[8]); else pass++;
    tot++; if (l_op[9] !== OP_NONE || l_op[10] !== OP_NONE) $display("FAIL single_gap got %0d,%0d want 0,0", l_op[9], l_op[10]); else pass++;
    for (int i = 11; i < 15; i++) begin
      tot++; if (l_op[i] !== OP_CHECK) $display("FAIL single_check[%0d] got %0d want 4", i, l_op[i]); else pass++;
    end
    for (int k = 0; k < 8; k++) begin
      tot++; if (l_op[15+k] !== OP_READ || l_addr[15+k] !== 3'(k) || l_dv[15+k] !== 1'b1 ||
                 l_di[15+k] !== 3'(k) || l_dd[15+k] !== exp_dig(0, k))
        $display("FAIL single_read[%0d] got op%0d a%0d v%b i%0d d%h want op1 a%0d v1 i%0d d%h",
                 k, l_op[15+k], l_addr[15+k], l_dv[15+k], l_di[15+k], l_dd[15+k], k, k, exp_dig(0, k));
      else pass++;
    end
    tot++; if (l_done[23] !== 2'b01 || l_err[23] !== 2'b00) $display("FAIL single_fin got done=%b err=%b want 01/00", l_done[23], l_err[23]); else pass++;
    nd = 0;
    for (int i = 0; i < n_log; i++) if (l_done[i] != '0) nd++;
    req = '0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0) nd++;
    end
    tot++; if (nd !== 1) $display("FAIL single_done_count got %0d want 1", nd); else pass++;
    tot++; if (busy !== 1'b0) $display("FAIL single_idle_after got busy=%b want 0", busy); else pass++;
  endtask

  task automatic test_contention();
    bit ok; int ns, nd, n2h;
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req = 2'b11;
    capture(4, 256, ok);
    tot++; if (!ok) $display("FAIL cont_done_seen got fewer than 4 dones want 4"); else pass++;
    ns = 0; nd = 0; n2h = 0;
    for (int i = 0; i < n_log; i++) begin
      if ($countones(l_gr[i]) > 1) n2h++;
      if (l_op[i] == OP_WRITE && l_addr[i] == 3'd0) begin
        if (ns < 4) begin
          tot++; if (l_gr[i] !== exp_g[ns]) $display("FAIL cont_grant[%0d] got %b want %b", ns, l_gr[i], exp_g[ns]); else pass++;
        end
        ns++;
      end
      if (l_done[i] != '0) begin
        if (nd < 4) begin
          tot++; if (l_done[i] !== exp_g[nd]) $display("FAIL cont_done[%0d] got %b want %b", nd, l_done[i], exp_g[nd]); else pass++;
        end
        if (i + 2 < n_log) begin
          tot++; if (l_op[i] !== OP_NONE || l_op[i+1] !== OP_NONE || l_op[i+2] !== OP_WRITE || l_addr[i+2] !== 3'd0)
            $display("FAIL cont_gap[%0d] got ops %0d,%0d,%0d want 0,0,2", nd, l_op[i], l_op[i+1], l_op[i+2]);
          else pass++;
        end
        nd++;
      end
    end
    tot++; if (ns !== 4) $display("FAIL cont_jobs got %0d want 4", ns); else pass++;
    tot++; if (nd !== 4) $display("FAIL cont_done_count got %0d want 4", nd); else pass++;
    tot++; if (n2h !== 0) $display("FAIL cont_two_hot got %0d cycles want 0", n2h); else pass++;
    req = '0;
  endtask

  task automatic test_timeout();
    bit ok; int nchk, nrd, ndv, nerr;
    do_reset();
    force_busy = 1'b1;
    req = 2'b01;
    capture(1, 100, ok);
    tot++; if (!ok) $display("FAIL tmo_done_seen got none want done within 100 cycles"); else pass++;
    nchk = 0; nrd = 0; ndv = 0; nerr = 0;
    for (int i = 0; i < n_log; i++) begin
      if (l_op[i] == OP_CHECK) nchk++;
      if (l_op[i] == OP_READ) nrd++;
      if (l_dv[i]) ndv++;
      if (l_err[i] != '0) nerr++;
    end
    tot++; if (nchk !== 16) $display("FAIL tmo_checks got %0d want 16", nchk); else pass++;
    tot++; if (nrd !== 0 || ndv !== 0) $display("FAIL tmo_no_read got reads=%0d dv=%0d want 0/0", nrd, ndv); else pass++;
    tot++; if (l_done[n_log-1] !== 2'b01 || l_err[n_log-1] !== 2'b01)
      $display("FAIL tmo_fin got done=%b err=%b want 01/01", l_done[n_log-1], l_err[n_log-1]);
    else pass++;
    tot++; if (nerr !== 1) $display("FAIL tmo_err_count got %0d want 1", nerr); else pass++;
    tot++; if (n_log !== 28) $display("FAIL tmo_length got %0d want 28", n_log); else pass++;
    req = '0; force_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    do_reset();
    req = 2'b01;
    repeat (5) @(negedge clk);
    tot++; if (p_opcode !== OP_WRITE || p_addr !== 3'd4) $display("FAIL rml_at_idx4 got op%0d a%0d want op2 a4", p_opcode, p_addr); else pass++;
    rst = 1'b1;
    @(negedge clk);
    tot++; if (p_opcode !== OP_NONE || grant !== 2'b00 || busy !== 1'b0 || done !== 2'b00)
      $display("FAIL rml_after got op%0d g%b b%b d%b want op0 g00 b0 d00", p_opcode, grant, busy, done);
    else pass++;
    rst = 1'b0;
    capture(1, 100, ok);
    tot++; if (!ok || n_log !== 24) $display("FAIL rml_rerun got ok=%0d len=%0d want 1/24", ok, n_log); else pass++;
    tot++; if (l_op[0] !== OP_WRITE || l_addr[0] !== 3'd0) $display("FAIL rml_restart got op%0d a%0d want op2 a0", l_op[0], l_addr[0]); else pass++;
    for (int k = 0; k < 8; k++) begin
      tot++; if (l_dd[15+k] !== exp_dig(0, k) || l_dv[15+k] !== 1'b1)
        $display("FAIL rml_digest[%0d] got v%b d%h want v1 d%h", k, l_dv[15+k], l_dd[15+k], exp_dig(0, k));
      else pass++;
    end
    req = '0;
  endtask

  task automatic test_early_release();
    bit ok; int nr;
    do_reset();
    req = 2'b10;
    drop_at_poll = 1'b1;
    capture(1, 100, ok);
    drop_at_poll = 1'b0;
    tot++; if (!ok) $display("FAIL early_done_seen got none want done within 100 cycles"); else pass++;
    tot++; if (l_gr[0] !== 2'b10) $display("FAIL early_grant got %b want 10", l_gr[0]); else pass++;
    nr = 0;
    for (int i = 0; i < n_log; i++) begin
      if (l_op[i] == OP_READ) begin
        tot++; if (l_dv[i] !== 1'b1 || l_di[i] !== 3'(nr) || l_dd[i] !== exp_dig(1, nr))
          $display("FAIL early_read[%0d] got v%b i%0d d%h want v1 i%0d d%h", nr, l_dv[i], l_di[i], l_dd[i], nr, exp_dig(1, nr));
        else pass++;
        nr++;
      end
    end
    tot++; if (nr !== 8) $display("FAIL early_read_count got %0d want 8", nr); else pass++;
    tot++; if (l_done[n_log-1] !== 2'b10) $display("FAIL early_done got %b want 10", l_done[n_log-1]); else pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok; int nbad;
    do_reset();
    req = 2'b01;
    capture(1, 100, ok);
    tot++; if (!ok || n_log !== 24) $display("FAIL b2b_first got ok=%0d len=%0d want 1/24", ok, n_log); else pass++;
    for (int i = 0; i < 24; i++) begin
      s_op[i] = l_op[i]; s_addr[i] = l_addr[i]; s_din[i] = l_din[i]; s_dd[i] = l_dd[i];
    end
    capture(1, 100, ok);
    tot++; if (!ok || n_log !== 25) $display("FAIL b2b_second got ok=%0d len=%0d want 1/25", ok, n_log); else pass++;
    tot++; if (l_op[0] !== OP_NONE || l_gr[0] !== 2'b00 || l_busy[0] !== 1'b0)
      $display("FAIL b2b_idle got op%0d g%b b%b want op0 g00 b0", l_op[0], l_gr[0], l_busy[0]);
    else pass++;
    tot++; if (l_gr[1] !== 2'b01) $display("FAIL b2b_regrant got %b want 01", l_gr[1]); else pass++;
    nbad = 0;
    for (int k = 0; k < 24; k++)
      if (l_op[k+1] !== s_op[k] || l_addr[k+1] !== s_addr[k] || l_din[k+1] !== s_din[k] || l_dd[k+1] !== s_dd[k]) nbad++;
    tot++; if (nbad !== 0) $display("FAIL b2b_identical got %0d differing cycles want 0", nbad); else pass++;
    tot++; if (l_done[24] !== 2'b01) $display("FAIL b2b_done got %b want 01", l_done[24]); else pass++;
    req = '0;
  endtask

  initial begin
    for (int w = 0; w < 8; w++) begin
      msg_tab[0][w] = 32'h11111111 * 32'(w + 1);
      msg_tab[1][w] = 32'hC0DE0000 + 32'h00000111 * 32'(w);
    end
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_reset_mid_load();
    test_early_release();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000 time units");
    $fatal(1);
  end

endmodule
